bitmap_fetch: RTL and testbench
===============================

BITMAP_FETCH -- requirements
Module: bitmap_fetch

Interface
REQ-001 SHALL have parameter X_W, default 11, meaning pixel x coordinate width.
REQ-002 SHALL have parameter Y_W, default 11, meaning pixel y coordinate width.
REQ-003 SHALL have parameter IMG_W, default 128, meaning bitmap width in pixels (multiple of DATA_W).
REQ-004 SHALL have parameter IMG_H, default 128, meaning bitmap height in pixels.
REQ-005 SHALL have parameter DATA_W, default 8, meaning ROM word width in pixels (power of 2, 1..32).
REQ-006 SHALL have parameter ADDR_W, default 11, meaning ROM address width, at least clog2(IMG_W/DATA_W*IMG_H).
REQ-007 SHALL have parameter ROM_LAT, default 1, meaning ROM read latency in cycles (1..4).
REQ-008 SHALL have parameter MSB_FIRST, default 1, meaning leftmost pixel is in the ROM word MSB.
REQ-009 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-010 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-011 SHALL have port x, input, X_W, current pixel column.
REQ-012 SHALL have port y, input, Y_W, current pixel row.
REQ-013 SHALL have port data_valid, input, 1, x/y qualify this cycle.
REQ-014 SHALL have port org_x, input, X_W, bitmap left edge on screen.
REQ-015 SHALL have port org_y, input, Y_W, bitmap top edge on screen.
REQ-016 SHALL have port scale, input, 2, magnification 2^scale (1x,2x,4x,8x).
REQ-017 SHALL have port rom_addr, output, ADDR_W, registered ROM word address.
REQ-018 SHALL have port rom_en, output, 1, ROM read enable.
REQ-019 SHALL have port rom_data, input, DATA_W, ROM word, valid ROM_LAT cycles after rom_en.
REQ-020 SHALL have port pix_on, output, 1, fetched pixel bit.
REQ-021 SHALL have port pix_in, output, 1, pixel lies inside bitmap region.
REQ-022 SHALL have port pix_valid, output, 1, qualifies pix_on/pix_in.

Function
REQ-023 Stage 1 (edge after sampling) SHALL register dx=x-org_x, dy=y-org_y and in-region flag plus valid.
REQ-024 In-region SHALL be org_x<=x<org_x+(IMG_W<<scale) and org_y<=y<org_y+(IMG_H<<scale), evaluated in X_W+4/Y_W+4 bits (no wrap; x<org_x is outside).
REQ-025 Stage 2 SHALL compute rx=dx>>scale, ry=dy>>scale, rom_addr=ry*(IMG_W/DATA_W)+rx/DATA_W, bit index=rx mod DATA_W.
REQ-026 rom_en SHALL assert in stage 2 only when stage-1 valid and in-region; otherwise rom_addr SHALL hold its previous value.
REQ-027 Index, in-region and valid SHALL be delayed ROM_LAT cycles by a shift pipeline aligned to rom_data.
REQ-028 Output stage SHALL register pix_on=rom_data[DATA_W-1-idx] (MSB_FIRST=1) or rom_data[idx] (MSB_FIRST=0) when in-region, else 0.
REQ-029 pix_valid SHALL assert exactly L=3+ROM_LAT edges after data_valid sampled high, one output per input, no drops or duplicates.
REQ-030 Out-of-region inputs SHALL still produce pix_valid=1 with pix_in=0, pix_on=0.
REQ-031 data_valid low SHALL produce pix_valid=0 L edges later; pix_on, pix_in SHALL be 0 whenever pix_valid=0.
REQ-032 Back-to-back valid inputs every cycle SHALL be sustained (throughput 1 pixel/cycle, no stall).
REQ-033 org_x, org_y, scale SHALL be sampled with x/y in stage 1; changes mid-stream affect only later pixels.

Reset
REQ-034 rst_n low at a clock edge SHALL clear rom_addr, rom_en, pix_on, pix_in, pix_valid and all pipeline valid/index bits to 0.
REQ-035 Reset mid-stream SHALL discard all in-flight pixels; first pix_valid after release SHALL be L edges after first sampled data_valid.

Verification
REQ-036 Defaults, org=0, scale=0, x=17, y=3, valid -> rom_addr=50, rom_en=1 at edge 2; rom_data=8'h40 -> pix_on=1, pix_valid=1 at edge 4.
REQ-037 org_x=100, org_y=50, scale=1, x=110, y=54 -> rx=5, ry=2, rom_addr=32, index 5; x=99 -> pix_valid=1, pix_in=0, rom_en=0.
REQ-038 Boundary: org=0, scale=0, x=127, y=127 -> rom_addr=2047, in; x=128 -> out; scale=3, x=1023 -> in, rom_addr=127*16+15 when y=1016.
REQ-039 Continuous 1000-pixel stream with random valid gaps, ROM_LAT=1 and 3 -> pix_valid pattern equals data_valid delayed by L, values match model.
REQ-040 Reset asserted with 3 pixels in flight -> next edge all outputs 0, no stale pix_valid emerges afterwards.
REQ-041 MSB_FIRST=0, DATA_W=16, x=3, rom_data=16'h0008 -> pix_on=1.

Source files
------------

// File: rtl/bitmap_fetch.sv
// Bitmap fetch pipeline: screen x/y -> ROM word address and bit index -> registered pixel.
// Fixed latency of 3+ROM_LAT edges, one pixel per cycle, no back-pressure.
module bitmap_fetch #(
    parameter int X_W       = 11,
    parameter int Y_W       = 11,
    parameter int IMG_W     = 128,
    parameter int IMG_H     = 128,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int ROM_LAT   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic              data_valid,
    input  logic [X_W-1:0]    org_x,
    input  logic [Y_W-1:0]    org_y,
    input  logic [1:0]        scale,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pix_on,
    output logic              pix_in,
    output logic              pix_valid
);
    localparam int WPR    = IMG_W / DATA_W;
    localparam int IDX_SH = $clog2(DATA_W);
    localparam int IDX_W  = (IDX_SH > 0) ? IDX_SH : 1;
    localparam int XE     = X_W + 4;
    localparam int YE     = Y_W + 4;

    // Region test is done 4 bits wider so org + (size << 3) can never wrap.
    logic [XE-1:0] x_ext, ox_ext, x_end;
    logic [YE-1:0] y_ext, oy_ext, y_end;
    logic          in_rgn;

    assign x_ext  = {4'b0, x};
    assign ox_ext = {4'b0, org_x};
    assign x_end  = ox_ext + (XE'(IMG_W) << scale);
    assign y_ext  = {4'b0, y};
    assign oy_ext = {4'b0, org_y};
    assign y_end  = oy_ext + (YE'(IMG_H) << scale);
    assign in_rgn = (x_ext >= ox_ext) && (x_ext < x_end) &&
                    (y_ext >= oy_ext) && (y_ext < y_end);

    logic           s1_vld, s1_in;
    logic [X_W-1:0] s1_dx;
    logic [Y_W-1:0] s1_dy;
    logic [1:0]     s1_scale;

    logic [X_W-1:0]    rx, rx_lo;
    logic [Y_W-1:0]    ry;
    logic [ADDR_W-1:0] addr_nxt;
    logic [IDX_W-1:0]  idx_nxt;

    assign rx       = s1_dx >> s1_scale;
    assign ry       = s1_dy >> s1_scale;
    assign rx_lo    = rx & X_W'(DATA_W - 1);
    assign idx_nxt  = rx_lo[IDX_W-1:0];
    assign addr_nxt = ADDR_W'(ry) * ADDR_W'(WPR) + ADDR_W'(rx >> IDX_SH);

    // Index/flags travel alongside the ROM access; entry ROM_LAT lines up with rom_data.
    logic [ROM_LAT:0]            vld_pipe, in_pipe;
    logic [ROM_LAT:0][IDX_W-1:0] idx_pipe;
    logic [IDX_W-1:0]            bsel;

    assign bsel = (MSB_FIRST != 0) ? IDX_W'(DATA_W - 1) - idx_pipe[ROM_LAT]
                                   : idx_pipe[ROM_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_in     <= 1'b0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_scale  <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            vld_pipe  <= '0;
            in_pipe   <= '0;
            idx_pipe  <= '0;
            pix_valid <= 1'b0;
            pix_in    <= 1'b0;
            pix_on    <= 1'b0;
        end else begin
            s1_vld   <= data_valid;
            s1_in    <= data_valid && in_rgn;
            s1_dx    <= x - org_x;
            s1_dy    <= y - org_y;
            s1_scale <= scale;

            rom_en <= s1_in;
            if (s1_in)
                rom_addr <= addr_nxt;
            vld_pipe[0] <= s1_vld;
            in_pipe[0]  <= s1_in;
            idx_pipe[0] <= idx_nxt;
            for (int k = 1; k <= ROM_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                in_pipe[k]  <= in_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end

            pix_valid <= vld_pipe[ROM_LAT];
            pix_in    <= in_pipe[ROM_LAT];
            pix_on    <= in_pipe[ROM_LAT] && rom_data[bsel];
        end
    end
endmodule

// File: tb/tb_bitmap_fetch.sv
// Directed and streamed checks of bitmap_fetch: default instance (8-bit words, latency 1)
// and a 16-bit LSB-first instance with latency 3, both fed the same pixel stream.
module tb_bitmap_fetch;
    logic        clk, rst_n, data_valid;
    logic [10:0] x, y, org_x, org_y;
    logic [1:0]  scale;

    logic [10:0] rom_addr_a, rom_addr_b;
    logic        rom_en_a, rom_en_b;
    logic [7:0]  rom_data_a;
    logic [15:0] rom_data_b, rb0, rb1;
    logic        pix_on_a, pix_in_a, pix_valid_a;
    logic        pix_on_b, pix_in_b, pix_valid_b;

    logic [7:0]  mem_a [0:2047];
    logic [15:0] mem_b [0:1023];
    logic [2:0]  ea [16];
    logic [2:0]  eb [16];

    int n_chk  = 0;
    int n_fail = 0;

    bitmap_fetch dut_a (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .data_valid(data_valid),
        .org_x(org_x), .org_y(org_y), .scale(scale),
        .rom_addr(rom_addr_a), .rom_en(rom_en_a), .rom_data(rom_data_a),
        .pix_on(pix_on_a), .pix_in(pix_in_a), .pix_valid(pix_valid_a)
    );

    bitmap_fetch #(.DATA_W(16), .MSB_FIRST(0), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .data_valid(data_valid),
        .org_x(org_x), .org_y(org_y), .scale(scale),
        .rom_addr(rom_addr_b), .rom_en(rom_en_b), .rom_data(rom_data_b),
        .pix_on(pix_on_b), .pix_in(pix_in_b), .pix_valid(pix_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en_a) rom_data_a <= mem_a[rom_addr_a];
        if (rom_en_b) rb0 <= mem_b[rom_addr_b[9:0]];
        rb1        <= rb0;
        rom_data_b <= rb1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_px(input int ix, input int iy, input int iox, input int ioy, input int isc);
        x     = 11'(ix);
        y     = 11'(iy);
        org_x = 11'(iox);
        org_y = 11'(ioy);
        scale = 2'(isc);
    endtask

    // One isolated pixel; checks address, exact output latency and no duplicate output.
    task automatic send_one(input string tag, input int ix, input int iy, input int iox,
                            input int ioy, input int isc, input int exp_addr, input logic exp_en,
                            input logic exp_in, input logic exp_on_a, input logic exp_on_b);
        set_px(ix, iy, iox, ioy, isc);
        data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        tick;
        chk({tag, " rom_en"}, rom_en_a, exp_en);
        chk({tag, " rom_addr"}, rom_addr_a, exp_addr);
        chk({tag, " early valid e2"}, pix_valid_a, 0);
        tick;
        chk({tag, " early valid e3"}, pix_valid_a, 0);
        tick;
        chk({tag, " a valid"}, pix_valid_a, 1);
        chk({tag, " a in"}, pix_in_a, exp_in);
        chk({tag, " a on"}, pix_on_a, exp_on_a);
        tick;
        chk({tag, " a dup"}, pix_valid_a, 0);
        tick;
        chk({tag, " b valid"}, pix_valid_b, 1);
        chk({tag, " b in"}, pix_in_b, exp_in);
        chk({tag, " b on"}, pix_on_b, exp_on_b);
        tick;
        chk({tag, " b dup"}, pix_valid_b, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a addr"}, rom_addr_a, 0);
        chk({tag, " a en"}, rom_en_a, 0);
        chk({tag, " a out"}, {pix_valid_a, pix_in_a, pix_on_a}, 0);
        chk({tag, " b addr"}, rom_addr_b, 0);
        chk({tag, " b en"}, rom_en_b, 0);
        chk({tag, " b out"}, {pix_valid_b, pix_in_b, pix_on_b}, 0);
    endtask

    function automatic logic [1:0] model_a(int ix, int iy, int iox, int ioy, int isc);
        int rx, ry;
        if (ix < iox || ix >= iox + (128 << isc) || iy < ioy || iy >= ioy + (128 << isc))
            return 2'b00;
        rx = (ix - iox) >> isc;
        ry = (iy - ioy) >> isc;
        return {1'b1, mem_a[ry * 16 + rx / 8][7 - rx % 8]};
    endfunction

    function automatic logic [1:0] model_b(int ix, int iy, int iox, int ioy, int isc);
        int rx, ry;
        if (ix < iox || ix >= iox + (128 << isc) || iy < ioy || iy >= ioy + (128 << isc))
            return 2'b00;
        rx = (ix - iox) >> isc;
        ry = (iy - ioy) >> isc;
        return {1'b1, mem_b[ry * 8 + rx / 16][rx % 16]};
    endfunction

    function automatic int clampi(int v);
        return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
    endfunction

    initial begin
        int sent, cyc, ox, oy, sc, xi, yi;
        logic v;
        logic [1:0] ma, mb;

        for (int i = 0; i < 2048; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 1024; i++) mem_b[i] = 16'h0000;
        mem_a[50]   = 8'h40;
        mem_a[32]   = 8'h04;
        mem_a[2047] = 8'h01;
        mem_b[1023] = 16'h8000;
        mem_b[0]    = 16'h0008;

        rst_n = 1'b0;
        data_valid = 1'b0;
        set_px(0, 0, 0, 0, 0);
        tick;
        tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick;

        send_one("basic",   17,   3,   0,  0, 0,   50, 1, 1, 1, 0);
        send_one("bit0",    16,   3,   0,  0, 0,   50, 1, 1, 0, 0);
        send_one("scale1", 110,  54, 100, 50, 1,   32, 1, 1, 1, 0);
        send_one("left",    99,  54, 100, 50, 1,   32, 0, 0, 0, 0);
        send_one("corner", 127, 127,   0,  0, 0, 2047, 1, 1, 1, 1);
        send_one("xout",   128, 127,   0,  0, 0, 2047, 0, 0, 0, 0);
        send_one("scale3",1023,1016,   0,  0, 3, 2047, 1, 1, 1, 1);
        send_one("lsb16",    3,   0,   0,  0, 0,    0, 1, 1, 0, 1);
        send_one("yout",     0, 128,   0,  0, 0,    0, 0, 0, 0, 0);

        // Three pixels in flight when reset hits.
        for (int i = 0; i < 3; i++) begin
            set_px(17, 3, 0, 0, 0);
            data_valid = 1'b1;
            tick;
        end
        data_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        chk_all_zero("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("post-reset a", pix_valid_a, 0);
            chk("post-reset b", pix_valid_b, 0);
        end
        send_one("after rst", 17, 3, 0, 0, 0, 50, 1, 1, 1, 0);

        for (int i = 0; i < 2048; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) mem_b[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            ea[i] = 3'b000;
            eb[i] = 3'b000;
        end

        // Random stream with gaps; org/scale change per pixel.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 || cyc < 2000) begin
            if (sent >= 1000 && cyc >= 8) begin
                v = 1'b0;
            end else begin
                v = ($urandom_range(0, 3) != 0) && (sent < 1000);
            end
            sc = int'($urandom_range(0, 3));
            ox = int'($urandom_range(0, 700));
            oy = int'($urandom_range(0, 700));
            xi = clampi(ox + int'($urandom_range(0, (128 << sc) + 15)) - 8);
            yi = clampi(oy + int'($urandom_range(0, (128 << sc) + 15)) - 8);
            set_px(xi, yi, ox, oy, sc);
            data_valid = v;
            ma = v ? model_a(xi, yi, ox, oy, sc) : 2'b00;
            mb = v ? model_b(xi, yi, ox, oy, sc) : 2'b00;
            ea[(cyc + 4) % 16] = {v, ma};
            eb[(cyc + 6) % 16] = {v, mb};
            if (v) sent++;
            tick;
            cyc++;
            chk("stream a", {pix_valid_a, pix_in_a, pix_on_a}, ea[cyc % 16]);
            chk("stream b", {pix_valid_b, pix_in_b, pix_on_b}, eb[cyc % 16]);
            if (sent >= 1000 && cyc >= 2000) break;
            if (sent >= 1000) begin
                data_valid = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    ea[(cyc + 4) % 16] = 3'b000;
                    eb[(cyc + 6) % 16] = 3'b000;
                    tick;
                    cyc++;
                    chk("drain a", {pix_valid_a, pix_in_a, pix_on_a}, ea[cyc % 16]);
                    chk("drain b", {pix_valid_b, pix_in_b, pix_on_b}, eb[cyc % 16]);
                end
                break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
